sc_intr_ctrl: RTL and testbench

//  Priority interrupt controller in front of the single-cycle CPU's intr/inta pins.

---
 rtl/sc_intr_ctrl_pkg.sv | 28 ++
 rtl/sc_intr_ctrl_prio.sv | 20 ++
 rtl/sc_intr_ctrl.sv | 128 ++++++++++++
 tb/tb_sc_intr_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_intr_ctrl_pkg.sv
// Shared types for the sc_intr_ctrl interrupt controller: register map codes
// and FSM state encodings.
package sc_intr_ctrl_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        INTC_MASK  = 2'd0,
        INTC_PEND  = 2'd1,
        INTC_INSRV = 2'd2,
        INTC_EOI   = 2'd3
    } cfg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_e;

    // One-hot decode of a source ID into an N-bit vector.
    function automatic logic [CFG_W-1:0] id_onehot(input int unsigned id);
        logic [CFG_W-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sc_intr_ctrl_prio.sv
// Combinational lowest-index-wins priority encoder; o_valid when any bit is set.
module sc_intr_prio #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_id = ID_W'(i);
        end
    end

endmodule

// File: rtl/sc_intr_ctrl.sv
// Priority interrupt controller for the single-cycle CPU intr/inta handshake.
// Define SC_INTR_NEST_EN to let higher-priority sources preempt an in-service one.
import sc_intr_ctrl_pkg::*;

module sc_intr_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic [N_SRC-1:0]  i_irq,
    output logic              o_intr,
    input  logic              i_inta,
    output logic [ID_W-1:0]   o_vec_id,
    input  logic              i_cfg_we,
    input  logic [1:0]        i_cfg_addr,
    input  logic [CFG_W-1:0]  i_cfg_wdata,
    output logic [CFG_W-1:0]  o_cfg_rdata
);

    logic [N_SRC-1:0] r_irq_q, r_mask, r_pend, r_insrv;
    logic [ID_W-1:0]  r_vec_id, w_vec_nxt;
    state_e           r_state, w_state_nxt;

    logic [N_SRC-1:0] w_rise, w_elig, w_wdata, w_ack_oh, w_eoi_oh;
    logic [N_SRC-1:0] w_pend_nxt, w_insrv_nxt;
    logic             w_win_vld, w_srv_vld;
    logic [ID_W-1:0]  w_win_id, w_srv_id;
    logic             w_wr_mask, w_wr_pend, w_wr_eoi, w_ack, w_eoi;
    cfg_addr_e        w_addr;
    logic [CFG_W-1:0] w_ack_full, w_eoi_full;
    logic             w_unused;

    assign w_addr   = cfg_addr_e'(i_cfg_addr);
    assign w_wdata  = i_cfg_wdata[N_SRC-1:0];
    assign w_rise   = i_irq & ~r_irq_q;
    assign w_elig   = r_pend & r_mask;

    sc_intr_prio #(.N(N_SRC), .ID_W(ID_W)) u_arb (
        .i_req   (w_elig),
        .o_valid (w_win_vld),
        .o_id    (w_win_id)
    );

    sc_intr_prio #(.N(N_SRC), .ID_W(ID_W)) u_srv (
        .i_req   (r_insrv),
        .o_valid (w_srv_vld),
        .o_id    (w_srv_id)
    );

    assign w_wr_mask = i_cfg_we && (w_addr == INTC_MASK);
    assign w_wr_pend = i_cfg_we && (w_addr == INTC_PEND);
    assign w_wr_eoi  = i_cfg_we && (w_addr == INTC_EOI);
    assign w_ack     = (r_state == ST_REQ) && i_inta;
    assign w_eoi     = w_wr_eoi && w_srv_vld;

    assign w_ack_full = id_onehot(32'(r_vec_id));
    assign w_eoi_full = id_onehot(32'(w_srv_id));
    assign w_ack_oh   = w_ack ? w_ack_full[N_SRC-1:0] : '0;
    assign w_eoi_oh   = w_eoi ? w_eoi_full[N_SRC-1:0] : '0;

    // New edges are OR'd in last so a set beats a same-cycle W1C.
    assign w_pend_nxt  = (r_pend & ~(w_wr_pend ? w_wdata : '0) & ~w_ack_oh) | w_rise;
    assign w_insrv_nxt = (r_insrv & ~w_eoi_oh) | w_ack_oh;

    assign w_unused = ^{i_cfg_wdata[CFG_W-1:N_SRC], w_ack_full[CFG_W-1:N_SRC],
                        w_eoi_full[CFG_W-1:N_SRC]};

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec_id;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_win_id;
                end
            end
            ST_REQ: begin
                if (i_inta) w_state_nxt = ST_SERV;
            end
            ST_SERV: begin
                if (w_insrv_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef SC_INTR_NEST_EN
                else if (w_win_vld && w_srv_vld && (w_win_id < w_srv_id)) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_win_id;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state  <= ST_IDLE;
            r_vec_id <= '0;
            r_irq_q  <= '0;
            r_mask   <= '0;
            r_pend   <= '0;
            r_insrv  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_vec_id <= w_vec_nxt;
            r_irq_q  <= i_irq;
            r_pend   <= w_pend_nxt;
            r_insrv  <= w_insrv_nxt;
            if (w_wr_mask) r_mask <= w_wdata;
        end
    end

    assign o_intr   = (r_state == ST_REQ);
    assign o_vec_id = r_vec_id;

    always_comb begin
        o_cfg_rdata = '0;
        case (w_addr)
            INTC_MASK:  o_cfg_rdata[N_SRC-1:0] = r_mask;
            INTC_PEND:  o_cfg_rdata[N_SRC-1:0] = r_pend;
            INTC_INSRV: o_cfg_rdata[N_SRC-1:0] = r_insrv;
            default:    o_cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sc_intr_ctrl.sv
// Scoreboard bench for sc_intr_ctrl: intr rising edges are checked against queued
// expected vector IDs; register state is checked directly through the cfg port.
module tb_sc_intr_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  irq = '0;
    logic        intr;
    logic        inta = 1'b0;
    logic [2:0]  vec_id;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;
    exp_t sb[$];

    sc_intr_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_irq       (irq),
        .o_intr      (intr),
        .i_inta      (inta),
        .o_vec_id    (vec_id),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_wdata (cfg_wdata),
        .o_cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, exp);
    endtask

    task automatic do_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic wait_intr(input string name);
        for (int n = 0; n < 20; n++) begin
            if (intr) break;
            tick();
        end
        check(name, {31'd0, intr}, 32'd1);
    endtask

    task automatic push(input int id, input int c);
        exp_t e;
        e.id = id; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge of intr must match the next expected request.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (intr && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL intr_unexpected actual vec_id=%0d expected none", vec_id);
                end else begin
                    e = sb.pop_front();
                    check("intr_vec_id", 32'(vec_id), 32'(e.id));
                    if (e.cyc >= 0) check("intr_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev = intr;
        end
    end

    initial begin
        tick(); tick();
        clr = 1'b0;
        check("rst_intr", {31'd0, intr}, 32'd0);
        check("rst_vec_id", 32'(vec_id), 32'd0);
        rd_check(2'd0, 32'h00, "rst_mask");
        rd_check(2'd1, 32'h00, "rst_pend");
        rd_check(2'd2, 32'h00, "rst_insrv");

        // 1: single source, exact latency
        cfg_wr(2'd0, 32'hFF);
        irq = 8'h08;
        push(3, cyc + 2);
        tick();
        irq = 8'h00;
        wait_intr("t1_wait");
        do_inta();
        check("t1_intr_after_ack", {31'd0, intr}, 32'd0);
        rd_check(2'd2, 32'h08, "t1_insrv");
        rd_check(2'd1, 32'h00, "t1_pend");
        cfg_wr(2'd3, 32'h0);
        rd_check(2'd2, 32'h00, "t1_insrv_eoi");

        // 2: simultaneous sources, priority order
        irq = 8'h24;
        push(2, -1);
        push(5, -1);
        tick();
        irq = 8'h00;
        wait_intr("t2_wait_a");
        do_inta();
        rd_check(2'd1, 32'h20, "t2_pend_after_ack");
        rd_check(2'd2, 32'h04, "t2_insrv");
        cfg_wr(2'd3, 32'h0);
        wait_intr("t2_wait_b");
        check("t2_vec5", 32'(vec_id), 32'd5);
        do_inta();
        cfg_wr(2'd3, 32'h0);

        // 3: masked source latches pend, unmask releases it
        cfg_wr(2'd0, 32'h00);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        tick(); tick();
        rd_check(2'd1, 32'h02, "t3_pend_masked");
        check("t3_no_intr", {31'd0, intr}, 32'd0);
        push(1, cyc + 2);
        cfg_wr(2'd0, 32'h02);
        wait_intr("t3_wait");
        do_inta();
        cfg_wr(2'd3, 32'h0);

        // 4/5: vec_id frozen in REQ; nesting behaviour depends on build
        cfg_wr(2'd0, 32'hFF);
        irq = 8'h10;
        push(4, -1);
        tick();
        irq = 8'h00;
        wait_intr("t4_wait");
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        check("t4_vec_frozen", 32'(vec_id), 32'd4);
        check("t4_intr_held", {31'd0, intr}, 32'd1);
        push(0, -1);
        do_inta();
        rd_check(2'd1, 32'h01, "t4_pend_kept");
`ifdef SC_INTR_NEST_EN
        wait_intr("t5_nest_wait");
        do_inta();
        rd_check(2'd2, 32'h11, "t5_insrv_nested");
        cfg_wr(2'd3, 32'h0);
        rd_check(2'd2, 32'h10, "t5_insrv_eoi1");
        cfg_wr(2'd3, 32'h0);
        rd_check(2'd2, 32'h00, "t5_insrv_eoi2");
`else
        rd_check(2'd2, 32'h10, "t4_insrv");
        tick(); tick(); tick();
        check("t4_no_nest", {31'd0, intr}, 32'd0);
        cfg_wr(2'd3, 32'h0);
        wait_intr("t4_wait_after_eoi");
        do_inta();
        cfg_wr(2'd3, 32'h0);
        rd_check(2'd2, 32'h00, "t4_insrv_done");
`endif

        // 6: reset mid-handshake, stray inta and EOI ignored
        irq = 8'h40;
        push(6, -1);
        tick();
        irq = 8'h00;
        wait_intr("t6_wait");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t6_intr", {31'd0, intr}, 32'd0);
        check("t6_vec_id", 32'(vec_id), 32'd0);
        rd_check(2'd0, 32'h00, "t6_mask");
        rd_check(2'd1, 32'h00, "t6_pend");
        rd_check(2'd2, 32'h00, "t6_insrv");
        do_inta();
        check("t6_stray_inta_intr", {31'd0, intr}, 32'd0);
        rd_check(2'd2, 32'h00, "t6_stray_inta_insrv");
        cfg_wr(2'd3, 32'hFF);
        rd_check(2'd2, 32'h00, "t6_eoi_idle");

        // Register-port boundaries: W1C, set-beats-clear, RO/WO behaviour
        irq = 8'h80;
        tick();
        irq = 8'h00;
        tick();
        rd_check(2'd1, 32'h80, "reg_pend_set");
        cfg_wr(2'd1, 32'h80);
        rd_check(2'd1, 32'h00, "reg_pend_w1c");
        irq = 8'h40;
        cfg_wr(2'd1, 32'h40);
        irq = 8'h00;
        rd_check(2'd1, 32'h40, "reg_set_wins");
        cfg_wr(2'd2, 32'hFF);
        rd_check(2'd2, 32'h00, "reg_insrv_ro");
        rd_check(2'd3, 32'h00, "reg_eoi_reads0");
        tick(); tick();
        check("no_intr_masked", {31'd0, intr}, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
